// File: rtl/cache_pkg.sv
// Shared cache read-path types: AXI burst encodings and the beat-generator FSM states.
package cache_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [0:0] {
        FSM_IDLE = 1'b0,
        FSM_SEND = 1'b1
    } fsm_t;

endpackage

// File: rtl/line_beat_extractor_if.sv
// Request descriptor and cache-side R channel between line select and AXI response logic.
interface line_beat_extractor_if #(
    parameter int LINE_BYTES = 8,
    parameter int DATA_BYTES = 1
);
    localparam int OFF_W = $clog2(LINE_BYTES);

    logic                    req_valid;
    logic                    req_ready;
    logic [LINE_BYTES*8-1:0] req_line;
    logic [OFF_W-1:0]        req_offset;
    logic [7:0]              req_len;
    logic [1:0]              req_burst;
    logic [DATA_BYTES*8-1:0] caRDATA;
    logic                    caRVALID;
    logic                    caRREADY;
    logic                    caRLAST;
    logic                    busy;

    modport master (
        output req_valid, req_line, req_offset, req_len, req_burst, caRREADY,
        input  req_ready, caRDATA, caRVALID, caRLAST, busy
    );

    modport slave (
        input  req_valid, req_line, req_offset, req_len, req_burst, caRREADY,
        output req_ready, caRDATA, caRVALID, caRLAST, busy
    );

endinterface

// File: rtl/byte_lane_select.sv
// Combinational lane mux: picks DATA_BYTES bytes of a line starting at a beat-aligned byte offset.
module byte_lane_select #(
    parameter int LINE_BYTES = 8,
    parameter int DATA_BYTES = 1
) (
    input  logic [LINE_BYTES*8-1:0]         line_i,
    input  logic [$clog2(LINE_BYTES)-1:0]   offset_i,
    output logic [DATA_BYTES*8-1:0]         data_o
);
    localparam int DATA_W = DATA_BYTES * 8;

    // Offset is beat-aligned, so the selected window never runs past the line end.
    assign data_o = DATA_W'(line_i >> {offset_i, 3'b000});

endmodule

// File: rtl/line_beat_extractor.sv
// Streams a latched cache line as FIXED/INCR/WRAP beats; 1-cycle accept-to-first-beat, outputs held under backpressure.
// WRAP addressing exists only when WRAP_BURST_EN is defined; otherwise WRAP requests run as INCR.
module line_beat_extractor
    import cache_pkg::*;
#(
    parameter int LINE_BYTES = 8,
    parameter int DATA_BYTES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    line_beat_extractor_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int DATA_W = DATA_BYTES * 8;

    localparam logic [OFF_W-1:0] STEP  = OFF_W'(DATA_BYTES);
    localparam logic [OFF_W-1:0] ALIGN = ~OFF_W'(DATA_BYTES - 1);

    localparam logic [0:0] ST_IDLE = FSM_IDLE;
    localparam logic [0:0] ST_SEND = FSM_SEND;

    logic [0:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic [OFF_W-1:0]  off_q,   off_d;
    logic [7:0]        cnt_q,   cnt_d;
    burst_t            burst_q, burst_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;

    logic              accept;
    logic              beat_done;
    logic [OFF_W-1:0]  req_off_al;
    logic [OFF_W-1:0]  off_inc;
    logic [OFF_W-1:0]  off_nxt;
    burst_t            burst_in;
    logic [LINE_W-1:0] sel_line;
    logic [OFF_W-1:0]  sel_off;
    logic [DATA_W-1:0] lane_dat;

`ifdef WRAP_BURST_EN
    logic [OFF_W-1:0]  mask_q, mask_d;
    logic [OFF_W-1:0]  wrap_mask_in;
    logic              wrap_ok;
    int                container;

    // Wrap container must be a power of two that fits in the line, else the burst degrades to INCR.
    always_comb begin
        container    = (int'(bus.req_len) + 1) * DATA_BYTES;
        wrap_ok      = ((container & (container - 1)) == 0) && (container <= LINE_BYTES);
        wrap_mask_in = OFF_W'(container - 1);
    end
`endif

    assign accept     = (state_q == ST_IDLE) && bus.req_valid;
    assign beat_done  = (state_q == ST_SEND) && bus.caRREADY;
    assign req_off_al = bus.req_offset & ALIGN;

    always_comb begin
        burst_in = BURST_INCR;
        case (bus.req_burst)
            2'b00:   burst_in = BURST_FIXED;
`ifdef WRAP_BURST_EN
            2'b10:   burst_in = wrap_ok ? BURST_WRAP : BURST_INCR;
`endif
            default: burst_in = BURST_INCR;
        endcase
    end

    always_comb begin
        off_inc = off_q + STEP;
        off_nxt = off_inc;
        case (burst_q)
            BURST_FIXED: off_nxt = off_q;
`ifdef WRAP_BURST_EN
            BURST_WRAP:  off_nxt = (off_q & ~mask_q) | (off_inc & mask_q);
`endif
            default:     off_nxt = off_inc;
        endcase
    end

    // One mux serves both the first beat (straight from the request) and every following beat.
    assign sel_line = accept ? bus.req_line : line_q;
    assign sel_off  = accept ? req_off_al   : off_nxt;

    byte_lane_select #(
        .LINE_BYTES (LINE_BYTES),
        .DATA_BYTES (DATA_BYTES)
    ) u_lane_sel (
        .line_i   (sel_line),
        .offset_i (sel_off),
        .data_o   (lane_dat)
    );

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef WRAP_BURST_EN
        mask_d  = mask_q;
`endif
        if (accept) begin
            state_d = ST_SEND;
            line_d  = bus.req_line;
            off_d   = req_off_al;
            cnt_d   = bus.req_len;
            burst_d = burst_in;
            data_d  = lane_dat;
            last_d  = (bus.req_len == 8'd0);
`ifdef WRAP_BURST_EN
            mask_d  = wrap_mask_in;
`endif
        end else if (beat_done) begin
            if (cnt_q == 8'd0) begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end else begin
                cnt_d  = cnt_q - 8'd1;
                off_d  = off_nxt;
                data_d = lane_dat;
                last_d = (cnt_q == 8'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            burst_q <= BURST_FIXED;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef WRAP_BURST_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef WRAP_BURST_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.caRVALID  = (state_q == ST_SEND);
    assign bus.busy      = (state_q == ST_SEND);
    assign bus.caRDATA   = data_q;
    assign bus.caRLAST   = last_q;

endmodule

// File: tb/tb_line_beat_extractor.sv
// Directed bench: byte-wide and 2-byte-wide extractors over the same line, sampled on the falling edge.
module tb_line_beat_extractor;

    localparam logic [63:0] LINE = 64'h8877665544332211;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    line_beat_extractor_if #(.LINE_BYTES(8), .DATA_BYTES(1)) bus0 ();
    line_beat_extractor_if #(.LINE_BYTES(8), .DATA_BYTES(2)) bus1 ();

    line_beat_extractor #(.LINE_BYTES(8), .DATA_BYTES(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    line_beat_extractor #(.LINE_BYTES(8), .DATA_BYTES(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic drive0(input logic [2:0] off, input logic [7:0] len, input logic [1:0] burst);
        bus0.req_offset = off;
        bus0.req_len    = len;
        bus0.req_burst  = burst;
        bus0.req_valid  = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", bus0.req_ready); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus0.busy); end
        n_checks++; if (bus0.caRVALID !== 1'b0) begin n_fail++; $display("FAIL reset caRVALID: got %b want 0", bus0.caRVALID); end
        n_checks++; if (bus0.caRLAST !== 1'b0) begin n_fail++; $display("FAIL reset caRLAST: got %b want 0", bus0.caRLAST); end
        n_checks++; if (bus0.caRDATA !== 8'h00) begin n_fail++; $display("FAIL reset caRDATA: got %h want 00", bus0.caRDATA); end
        n_checks++; if (bus1.caRDATA !== 16'h0000) begin n_fail++; $display("FAIL reset wide caRDATA: got %h want 0000", bus1.caRDATA); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus0.caRVALID !== 1'b0) begin n_fail++; $display("FAIL idle caRVALID: got %b want 0", bus0.caRVALID); end
    endtask

    task automatic test_incr();
        logic [7:0] exp [4];
        exp = '{8'h66, 8'h77, 8'h88, 8'h11};
        drive0(3'd5, 8'd3, 2'b01);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus0.caRVALID !== 1'b1) begin n_fail++; $display("FAIL incr beat%0d valid: got %b want 1", i, bus0.caRVALID); end
            n_checks++; if (bus0.caRDATA !== exp[i]) begin n_fail++; $display("FAIL incr beat%0d data: got %h want %h", i, bus0.caRDATA, exp[i]); end
            n_checks++; if (bus0.caRLAST !== (i == 3)) begin n_fail++; $display("FAIL incr beat%0d last: got %b want %b", i, bus0.caRLAST, (i == 3)); end
            n_checks++; if (bus0.req_ready !== 1'b0) begin n_fail++; $display("FAIL incr beat%0d req_ready: got %b want 0", i, bus0.req_ready); end
            @(negedge clk);
        end
        n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL incr end req_ready: got %b want 1", bus0.req_ready); end
        n_checks++; if (bus0.caRVALID !== 1'b0) begin n_fail++; $display("FAIL incr end caRVALID: got %b want 0", bus0.caRVALID); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL incr end busy: got %b want 0", bus0.busy); end
    endtask

    task automatic test_backpressure();
        drive0(3'd5, 8'd3, 2'b01);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        n_checks++; if (bus0.caRDATA !== 8'h66) begin n_fail++; $display("FAIL bp beat0 data: got %h want 66", bus0.caRDATA); end
        @(negedge clk);
        bus0.caRREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus0.caRDATA !== 8'h77) begin n_fail++; $display("FAIL bp hold%0d data: got %h want 77", i, bus0.caRDATA); end
            n_checks++; if (bus0.caRVALID !== 1'b1) begin n_fail++; $display("FAIL bp hold%0d valid: got %b want 1", i, bus0.caRVALID); end
            n_checks++; if (bus0.caRLAST !== 1'b0) begin n_fail++; $display("FAIL bp hold%0d last: got %b want 0", i, bus0.caRLAST); end
            if (i < 3) @(negedge clk);
        end
        bus0.caRREADY = 1'b1;
        @(negedge clk);
        n_checks++; if (bus0.caRDATA !== 8'h88) begin n_fail++; $display("FAIL bp beat2 data: got %h want 88", bus0.caRDATA); end
        @(negedge clk);
        n_checks++; if (bus0.caRDATA !== 8'h11 || bus0.caRLAST !== 1'b1) begin n_fail++; $display("FAIL bp beat3 data/last: got %h/%b want 11/1", bus0.caRDATA, bus0.caRLAST); end
        @(negedge clk);
        n_checks++; if (bus0.caRVALID !== 1'b0) begin n_fail++; $display("FAIL bp end caRVALID: got %b want 0", bus0.caRVALID); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4];
`ifdef WRAP_BURST_EN
        exp = '{8'h66, 8'h77, 8'h88, 8'h55};
`else
        exp = '{8'h66, 8'h77, 8'h88, 8'h11};
`endif
        drive0(3'd5, 8'd3, 2'b10);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus0.caRDATA !== exp[i]) begin n_fail++; $display("FAIL wrap beat%0d data: got %h want %h", i, bus0.caRDATA, exp[i]); end
            n_checks++; if (bus0.caRLAST !== (i == 3)) begin n_fail++; $display("FAIL wrap beat%0d last: got %b want %b", i, bus0.caRLAST, (i == 3)); end
            @(negedge clk);
        end
    endtask

    task automatic test_fixed();
        drive0(3'd2, 8'd2, 2'b00);
        @(negedge clk);
        // Competing request held during the burst must not be taken.
        drive0(3'd0, 8'd0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus0.caRDATA !== 8'h33) begin n_fail++; $display("FAIL fixed beat%0d data: got %h want 33", i, bus0.caRDATA); end
            n_checks++; if (bus0.caRLAST !== (i == 2)) begin n_fail++; $display("FAIL fixed beat%0d last: got %b want %b", i, bus0.caRLAST, (i == 2)); end
            n_checks++; if (bus0.req_ready !== 1'b0) begin n_fail++; $display("FAIL fixed beat%0d req_ready: got %b want 0", i, bus0.req_ready); end
            if (i == 2) bus0.req_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (bus0.caRVALID !== 1'b0) begin n_fail++; $display("FAIL fixed end caRVALID: got %b want 0", bus0.caRVALID); end
        @(negedge clk);
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL fixed late busy: got %b want 0", bus0.busy); end
    endtask

    task automatic test_reset_mid_burst();
        drive0(3'd0, 8'd5, 2'b01);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        n_checks++; if (bus0.caRDATA !== 8'h11) begin n_fail++; $display("FAIL rstmid beat0 data: got %h want 11", bus0.caRDATA); end
        @(negedge clk);
        n_checks++; if (bus0.caRDATA !== 8'h22) begin n_fail++; $display("FAIL rstmid beat1 data: got %h want 22", bus0.caRDATA); end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (bus0.caRVALID !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d caRVALID: got %b want 0", i, bus0.caRVALID); end
            n_checks++; if (bus0.caRDATA !== 8'h00) begin n_fail++; $display("FAIL rstmid%0d caRDATA: got %h want 00", i, bus0.caRDATA); end
            n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid%0d req_ready: got %b want 1", i, bus0.req_ready); end
            n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d busy: got %b want 0", i, bus0.busy); end
            n_checks++; if (bus0.caRLAST !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d caRLAST: got %b want 0", i, bus0.caRLAST); end
            @(negedge clk);
        end
        rst = 1'b0;
        drive0(3'd6, 8'd1, 2'b01);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        n_checks++; if (bus0.caRDATA !== 8'h77 || bus0.caRLAST !== 1'b0) begin n_fail++; $display("FAIL rstmid new beat0: got %h/%b want 77/0", bus0.caRDATA, bus0.caRLAST); end
        @(negedge clk);
        n_checks++; if (bus0.caRDATA !== 8'h88 || bus0.caRLAST !== 1'b1) begin n_fail++; $display("FAIL rstmid new beat1: got %h/%b want 88/1", bus0.caRDATA, bus0.caRLAST); end
        @(negedge clk);
    endtask

    task automatic test_wide();
        bus1.req_offset = 3'd3;
        bus1.req_len    = 8'd1;
        bus1.req_burst  = 2'b01;
        bus1.req_valid  = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        n_checks++; if (bus1.caRVALID !== 1'b1) begin n_fail++; $display("FAIL wide beat0 valid: got %b want 1", bus1.caRVALID); end
        n_checks++; if (bus1.caRDATA !== 16'h4433) begin n_fail++; $display("FAIL wide beat0 data: got %h want 4433", bus1.caRDATA); end
        n_checks++; if (bus1.caRLAST !== 1'b0) begin n_fail++; $display("FAIL wide beat0 last: got %b want 0", bus1.caRLAST); end
        @(negedge clk);
        n_checks++; if (bus1.caRDATA !== 16'h6655) begin n_fail++; $display("FAIL wide beat1 data: got %h want 6655", bus1.caRDATA); end
        n_checks++; if (bus1.caRLAST !== 1'b1) begin n_fail++; $display("FAIL wide beat1 last: got %b want 1", bus1.caRLAST); end
        @(negedge clk);
        n_checks++; if (bus1.caRVALID !== 1'b0 || bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL wide end valid/ready: got %b/%b want 0/1", bus1.caRVALID, bus1.req_ready); end
    endtask

    initial begin
        bus0.req_valid  = 1'b0;
        bus0.req_line   = LINE;
        bus0.req_offset = '0;
        bus0.req_len    = '0;
        bus0.req_burst  = 2'b01;
        bus0.caRREADY   = 1'b1;
        bus1.req_valid  = 1'b0;
        bus1.req_line   = LINE;
        bus1.req_offset = '0;
        bus1.req_len    = '0;
        bus1.req_burst  = 2'b01;
        bus1.caRREADY   = 1'b1;

        test_reset();
        test_incr();
        test_backpressure();
        test_wrap();
        test_fixed();
        test_reset_mid_burst();
        test_wide();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_beat_extractor.md
# line_beat_extractor

Parametrised read-beat generator for the cache read path. It captures one cache line plus an AXI-style burst descriptor, then streams `DATA_BYTES`-wide beats from that line onto the cache-side R channel. Each beat is a valid/ready transfer, and the last beat carries `caRLAST`. It sits between the data-array line select and the AXI R-channel response logic. It replaces single-byte offset extraction with multi-width, multi-beat, back-pressured delivery.

## Interface
Parameters:
- `LINE_BYTES`, default 8: bytes per cache line. Must be a power of 2, ≥2.
- `DATA_BYTES`, default 1: bytes per beat. Must be a power of 2, ≤ `LINE_BYTES`.
- `OFF_W`, derived as `$clog2(LINE_BYTES)`: byte-offset width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `req_valid` in 1: request descriptor valid.
- `req_ready` out 1: block can accept a request.
- `req_line` in `LINE_BYTES*8`: cache line, byte 0 in bits [7:0].
- `req_offset` in `OFF_W`: start byte offset within the line.
- `req_len` in 8: beats minus one (ARLEN semantics).
- `req_burst` in 2: burst type. 00 = FIXED, 01 = INCR, 10 = WRAP, 11 = reserved.
- `caRDATA` out `DATA_BYTES*8`: beat data.
- `caRVALID` out 1: beat valid.
- `caRREADY` in 1: downstream accepts beat.
- `caRLAST` out 1: final beat of burst.
- `busy` out 1: burst in progress (state ≠ IDLE).

## Operation
- FSM has two states: IDLE and SEND.
  - IDLE: `req_ready`=1. On `req_valid && req_ready`:
    - latch `req_line`;
    - latch `req_offset & ~(DATA_BYTES-1)` (aligned down to beat boundary);
    - load beat counter with `req_len`;
    - latch burst type;
    - go to SEND.
  - SEND: `req_ready`=0. The current beat is presented from the registered offset.
    - On `caRVALID && caRREADY` with counter = 0: go to IDLE.
    - Otherwise on that handshake: decrement the counter and advance the offset.
- Beat data: `caRDATA` = `DATA_BYTES` bytes of the latched line starting at the current offset.
- `caRLAST` = SEND and counter == 0.
- Offset advance is computed modulo `LINE_BYTES`, carry discarded:
  - FIXED: offset unchanged.
  - INCR and reserved (11): offset + `DATA_BYTES`.
  - WRAP: container = (`req_len`+1)·`DATA_BYTES`.
    - Valid only if the container is a power of 2 and ≤ `LINE_BYTES`; otherwise behave as INCR.
    - Base = offset & ~(container−1).
    - Next = base | ((offset + `DATA_BYTES`) & (container−1)).
- `caRDATA` and `caRLAST` are held stable while `caRVALID && !caRREADY`.
- A new `req_valid` presented during SEND is ignored; it is not latched.
- Reset asserted mid-burst aborts the burst at once: state → IDLE, outputs go to reset values. No partial beat is completed.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1, `busy`=0;
  - `caRVALID`=0, `caRLAST`=0, `caRDATA`=0;
  - counter 0, offset 0.
- Accept on edge N → `caRVALID`=1 with beat 0 from cycle N+1.
- Accept-to-first-beat latency is 1 cycle.
- With `caRREADY` held high, one beat transfers per cycle. A burst occupies `req_len`+1 cycles in SEND.
- Last handshake on edge M → IDLE from cycle M+1: `req_ready`=1, `caRVALID`=0.
- The earliest next accept is edge M+1, giving a one-cycle bubble between bursts.
- `caRDATA`/`caRLAST` are registered outputs with no combinational path from `caRREADY`.
- `caRVALID` never drops without a handshake except on reset.

## Configuration
- `WRAP_BURST_EN` defined: WRAP addressing is implemented as in Operation.
- `WRAP_BURST_EN` undefined: `req_burst`=10 is treated as INCR. The container logic is not synthesised.

## Structure
- Shared package `cache_pkg`:
  - `burst_t` enum (BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10);
  - `fsm_t` enum for IDLE/SEND.
- Sub-module `byte_lane_select`, parametrised by `LINE_BYTES` and `DATA_BYTES`:
  - combinational line-to-beat lane mux driven by the aligned offset;
  - the generalised successor of single-byte extraction;
  - feeds the `caRDATA` register.

## Test plan
Common setup: `LINE_BYTES`=8, `DATA_BYTES`=1, `req_line`=64'h8877665544332211.
1. INCR, offset 5, len 3, `caRREADY`=1 → beats 0x66, 0x77, 0x88, 0x11 on consecutive cycles. `caRLAST` on 0x11 only. `req_ready` returns 1 the cycle after.
2. Same as 1, with `caRREADY` low for 3 cycles while 0x77 is presented → `caRDATA` holds 0x77, `caRVALID` stays 1. Resumes with 0x88, 0x11.
3. WRAP, offset 5, len 3, `WRAP_BURST_EN` defined → 0x66, 0x77, 0x88, 0x55. Without the macro → 0x66, 0x77, 0x88, 0x11.
4. FIXED, offset 2, len 2 → 0x33, 0x33, 0x33, `caRLAST` on the third. A `req_valid` asserted during the burst is not accepted.
5. INCR, len 5, assert `rst` after the first handshake → `caRVALID`=0, `caRDATA`=0, `req_ready`=1, `busy`=0 while reset is held. A new request after release streams from its own offset.
6. `DATA_BYTES`=2, INCR, offset 3, len 1 → offset aligned to 2, beats 0x4433 then 0x6655 with `caRLAST`.
